// File: rtl/ps2_key_decoder.sv
// Turns scan-code bytes from the ps2_keyboard FIFO into key events with make/break, extended,
// repeat and held-key state. Define PS2DEC_TYPEMATIC_FILTER_EN to drop typematic repeat events.
module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_repeat,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow
);

`ifdef PS2DEC_TYPEMATIC_FILTER_EN
    localparam logic FILTER_REPEATS = 1'b1;
`else
    localparam logic FILTER_REPEATS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic             r_nextdata_n, w_nextdata_n_next;
    logic             r_key_valid, w_key_valid_next;
    logic [7:0]       r_key_code, w_key_code_next;
    logic             r_key_ext, w_key_ext_next;
    logic             r_key_release, w_key_release_next;
    logic             r_key_repeat, w_key_repeat_next;
    logic             r_key_held, w_key_held_next;
    logic [7:0]       r_held_code, w_held_code_next;
    logic             r_held_ext, w_held_ext_next;
    logic [CNT_W-1:0] r_press_count, w_press_count_next;
    logic             r_err_overflow, w_err_overflow_next;
    logic             r_ext_pend, w_ext_pend_next;
    logic             r_brk_pend, w_brk_pend_next;

    logic w_capture;
    logic w_is_ext;
    logic w_is_brk;
    logic w_is_ctl;
    logic w_match;
    logic w_repeat;

    assign w_capture = (r_state == S_IDLE) && ready;
    assign w_is_ext  = (data == 8'hE0);
    assign w_is_brk  = (data == 8'hF0);
    assign w_is_ctl  = (data == 8'hE1) || (data == 8'hAA) || (data == 8'hFA) ||
                       (data == 8'hFE) || (data == 8'hEE) || (data == 8'h00) ||
                       (data == 8'hFF);
    // The held key is identified by the extended prefix as well as the code byte.
    assign w_match   = r_key_held && (r_held_ext == r_ext_pend) && (r_held_code == data);
    assign w_repeat  = w_match && !r_brk_pend;

    always_comb begin
        w_state_next        = r_state;
        w_nextdata_n_next   = 1'b1;
        w_key_valid_next    = 1'b0;
        w_key_code_next     = r_key_code;
        w_key_ext_next      = r_key_ext;
        w_key_release_next  = r_key_release;
        w_key_repeat_next   = r_key_repeat;
        w_key_held_next     = r_key_held;
        w_held_code_next    = r_held_code;
        w_held_ext_next     = r_held_ext;
        w_press_count_next  = r_press_count;
        w_err_overflow_next = r_err_overflow;
        w_ext_pend_next     = r_ext_pend;
        w_brk_pend_next     = r_brk_pend;

        case (r_state)
            S_IDLE:   if (ready) w_state_next = S_POP;
            S_POP:    w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        if (w_capture) begin
            w_nextdata_n_next = 1'b0;
            if (w_is_ext) begin
                w_ext_pend_next = 1'b1;
            end else if (w_is_brk) begin
                w_brk_pend_next = 1'b1;
            end else if (w_is_ctl) begin
                w_ext_pend_next = 1'b0;
                w_brk_pend_next = 1'b0;
            end else begin
                w_ext_pend_next = 1'b0;
                w_brk_pend_next = 1'b0;
                if (!(w_repeat && FILTER_REPEATS)) begin
                    w_key_valid_next   = 1'b1;
                    w_key_code_next    = data;
                    w_key_ext_next     = r_ext_pend;
                    w_key_release_next = r_brk_pend;
                    w_key_repeat_next  = w_repeat;
                end
                if (!r_brk_pend) begin
                    if (!w_match) begin
                        w_key_held_next    = 1'b1;
                        w_held_code_next   = data;
                        w_held_ext_next    = r_ext_pend;
                        w_press_count_next = r_press_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (w_match) begin
                    w_key_held_next  = 1'b0;
                    w_held_code_next = 8'h00;
                    w_held_ext_next  = 1'b0;
                end
            end
        end

        // Overflow discards prefixes after any same-cycle byte was decoded with the old ones.
        if (overflow) begin
            w_err_overflow_next = 1'b1;
            w_ext_pend_next     = 1'b0;
            w_brk_pend_next     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state        <= S_IDLE;
            r_nextdata_n   <= 1'b1;
            r_key_valid    <= 1'b0;
            r_key_code     <= 8'h00;
            r_key_ext      <= 1'b0;
            r_key_release  <= 1'b0;
            r_key_repeat   <= 1'b0;
            r_key_held     <= 1'b0;
            r_held_code    <= 8'h00;
            r_held_ext     <= 1'b0;
            r_press_count  <= '0;
            r_err_overflow <= 1'b0;
            r_ext_pend     <= 1'b0;
            r_brk_pend     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_nextdata_n   <= w_nextdata_n_next;
            r_key_valid    <= w_key_valid_next;
            r_key_code     <= w_key_code_next;
            r_key_ext      <= w_key_ext_next;
            r_key_release  <= w_key_release_next;
            r_key_repeat   <= w_key_repeat_next;
            r_key_held     <= w_key_held_next;
            r_held_code    <= w_held_code_next;
            r_held_ext     <= w_held_ext_next;
            r_press_count  <= w_press_count_next;
            r_err_overflow <= w_err_overflow_next;
            r_ext_pend     <= w_ext_pend_next;
            r_brk_pend     <= w_brk_pend_next;
        end
    end

    assign nextdata_n   = r_nextdata_n;
    assign key_valid    = r_key_valid;
    assign key_code     = r_key_code;
    assign key_ext      = r_key_ext;
    assign key_release  = r_key_release;
    assign key_repeat   = r_key_repeat;
    assign key_held     = r_key_held;
    assign held_code    = r_held_code;
    assign press_count  = r_press_count;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a queue models the upstream FIFO, directed vectors cover the
// documented sequences, and random byte streams are checked against a key-state model.
module tb_ps2_key_decoder;

    localparam int CNT_W = 8;
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             clrn = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             ready = 1'b0;
    logic             overflow = 1'b0;
    logic             nextdata_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_release;
    logic             key_repeat;
    logic             key_held;
    logic [7:0]       held_code;
    logic [CNT_W-1:0] press_count;
    logic             err_overflow;

    ps2_key_decoder #(.CNT_W(CNT_W)) dut (
        .clock(clock), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_release(key_release), .key_repeat(key_repeat),
        .key_held(key_held), .held_code(held_code), .press_count(press_count),
        .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic       held;
        logic [7:0] hc;
        logic [7:0] cnt;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         ev;
        ev_t        e;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       prev_pop = 1'b0;
    ev_t        exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cycles[$];
    vec_t       tab[$];

    // Reference key state: held key as (ext*256 + code) or -1, counts as plain integers.
    int m_held;
    bit m_ext;
    bit m_brk;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Upstream FIFO: pops on the cycle nextdata_n is low, and every event is scored here.
    always @(negedge clock) begin
        ev_t e;
        cyc++;
        if (clrn) begin
            if (!nextdata_n) begin
                chk("pop_twice_in_a_row", {31'd0, prev_pop}, 32'd0);
                pop_cycles.push_back(cyc);
                if (fifo_q.size() > 0) fifo_q.delete(0);
            end
            if (key_valid) begin
                chk("valid_with_pop", {31'd0, nextdata_n}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %0h rel %0b rep %0b expected no event",
                             key_code, key_release, key_repeat);
                end else begin
                    e = exp_q.pop_front();
                    $display("event code=%0h ext=%0b rel=%0b rep=%0b held=%0b hc=%0h cnt=%0d",
                             key_code, key_ext, key_release, key_repeat, key_held, held_code, press_count);
                    chk("key_code", {24'd0, key_code}, {24'd0, e.code});
                    chk("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
                    chk("key_release", {31'd0, key_release}, {31'd0, e.rel});
                    chk("key_repeat", {31'd0, key_repeat}, {31'd0, e.rep});
                    chk("key_held", {31'd0, key_held}, {31'd0, e.held});
                    chk("held_code", {24'd0, held_code}, {24'd0, e.hc});
                    chk("press_count", {24'd0, press_count}, {24'd0, e.cnt});
                end
            end
        end
        prev_pop = clrn && !nextdata_n;
        ready = (fifo_q.size() != 0);
        data  = ready ? fifo_q[0] : 8'h00;
    end

    task automatic add(input logic [7:0] b, input bit ev, input logic [7:0] code, input logic ext,
                       input logic rel, input logic rep, input logic held, input logic [7:0] hc,
                       input logic [7:0] cnt);
        vec_t v;
        v.b = b; v.ev = ev;
        v.e.code = code; v.e.ext = ext; v.e.rel = rel; v.e.rep = rep;
        v.e.held = held; v.e.hc = hc; v.e.cnt = cnt;
        tab.push_back(v);
    endtask

    task automatic model_reset();
        m_held = -1; m_ext = 0; m_brk = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        int  key;
        bit  rep;
        fifo_q.push_back(b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
            m_ext = 0; m_brk = 0;
        end else begin
            key = (m_ext ? 256 : 0) + int'(b);
            rep = !m_brk && (m_held == key);
            if (!m_brk) begin
                if (!rep) begin
                    m_held = key;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                end
            end else if (m_held == key) begin
                m_held = -1;
            end
            e.code = b; e.ext = m_ext; e.rel = m_brk; e.rep = rep;
            e.held = (m_held >= 0);
            e.hc   = (m_held >= 0) ? 8'(m_held % 256) : 8'h00;
            e.cnt  = 8'(m_cnt);
            if (!(rep && FILT)) exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (fifo_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", fifo_q.size());
            fifo_q.delete();
        end
        repeat (4) @(negedge clock);
        chk("events_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_nextdata_n"}, {31'd0, nextdata_n}, 32'd1);
        chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_key_code"}, {24'd0, key_code}, 32'd0);
        chk({tag, "_flags"}, {28'd0, key_ext, key_release, key_repeat, key_held}, 32'd0);
        chk({tag, "_held_code"}, {24'd0, held_code}, 32'd0);
        chk({tag, "_press_count"}, {24'd0, press_count}, 32'd0);
        chk({tag, "_err_overflow"}, {31'd0, err_overflow}, 32'd0);
    endtask

    initial begin
        int  found;
        ev_t e;
        logic [7:0] pool [8];

        //   byte   ev code   ext rel rep held hc     cnt
        add(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'd1);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'h00, 8'd1);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h75, 1, 8'h75, 1, 0, 0, 1, 8'h75, 8'd2);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h75, 1, 8'h75, 1, 1, 0, 0, 8'h00, 8'd2);
        add(8'h1B, 1, 8'h1B, 0, 0, 0, 1, 8'h1B, 8'd3);
        add(8'h1B, 1, 8'h1B, 0, 0, 1, 1, 8'h1B, 8'd3);
        add(8'h1B, 1, 8'h1B, 0, 0, 1, 1, 8'h1B, 8'd3);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1B, 1, 8'h1B, 0, 1, 0, 0, 8'h00, 8'd3);
        add(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'd4);
        add(8'h1B, 1, 8'h1B, 0, 0, 0, 1, 8'h1B, 8'd5);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 0, 1, 0, 1, 8'h1B, 8'd5);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'hAA, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'd6);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'h00, 8'd6);
        add(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'd7);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 1, 0, 0, 1, 8'h1C, 8'd8);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 0, 1, 0, 1, 8'h1C, 8'd8);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0);
        add(8'h1C, 1, 8'h1C, 1, 1, 0, 0, 8'h00, 8'd8);

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        clrn = 1'b1;
        repeat (2) @(negedge clock);

        // Directed table, pushed all at once so ready stays high between pops.
        pop_cycles.delete();
        foreach (tab[i]) begin
            fifo_q.push_back(tab[i].b);
            if (tab[i].ev && !(tab[i].e.rep && FILT)) exp_q.push_back(tab[i].e);
        end
        drain();
        chk("table_pop_count", pop_cycles.size(), tab.size());
        if (pop_cycles.size() >= 3) begin
            chk("pop_spacing_1", pop_cycles[1] - pop_cycles[0], 32'd3);
            chk("pop_spacing_2", pop_cycles[2] - pop_cycles[1], 32'd3);
        end

        // Overflow after F0 discards the break prefix.
        fifo_q.push_back(8'hF0);
        drain();
        chk("err_overflow_before", {31'd0, err_overflow}, 32'd0);
        overflow = 1'b1;
        @(negedge clock);
        overflow = 1'b0;
        @(negedge clock);
        chk("err_overflow_set", {31'd0, err_overflow}, 32'd1);
        e.code = 8'h1C; e.ext = 0; e.rel = 0; e.rep = 0; e.held = 1; e.hc = 8'h1C; e.cnt = 8'd9;
        fifo_q.push_back(8'h1C);
        exp_q.push_back(e);
        drain();
        chk("err_overflow_sticky", {31'd0, err_overflow}, 32'd1);

        // Reset during the POP cycle of an F0 byte.
        fifo_q.push_back(8'hF0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock);
            if (!nextdata_n) found = 1;
        end
        chk("pop_seen_before_reset", found, 32'd1);
        #1 clrn = 1'b0;
        #1 check_reset_outputs("abort");
        fifo_q.delete();
        @(negedge clock);
        @(negedge clock);
        clrn = 1'b1;
        model_reset();
        model_byte(8'h1C);
        drain();

        // press_count wrap: 255 further new makes bring the count back to zero.
        for (int i = 0; i < 255; i++) model_byte((i % 2 == 0) ? 8'h23 : 8'h1C);
        drain();
        chk("press_count_wrap", {24'd0, press_count}, 32'd0);

        // Random streams over a small code pool so repeats, breaks and prefixes collide.
        pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'h23; pool[3] = 8'h75;
        pool[4] = 8'hE0; pool[5] = 8'hF0; pool[6] = 8'hAA; pool[7] = 8'hF0;
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 50; i++) model_byte(pool[$urandom_range(0, 7)]);
            drain();
            chk("rand_press_count", {24'd0, press_count}, m_cnt);
            chk("rand_key_held", {31'd0, key_held}, (m_held >= 0) ? 32'd1 : 32'd0);
            chk("rand_held_code", {24'd0, held_code}, (m_held >= 0) ? (m_held % 256) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
